// File: rtl/core_mem_port.sv
//------------------------------------------------------------------------------
// Module   : core_mem_port
// Brief    : Load/store transfer responder; runs one Avalon-MM access per
//            request and returns lane-aligned, size-extended read data.
//            Optional macro CORE_MEM_UNALIGNED_ROTATE_EN rotates unaligned
//            word loads (ARM LDR style).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module core_mem_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [1:0]  size,
  input  logic        sign_extend,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        abort,
  output logic        busy,
  output logic [29:0] avl_address,
  output logic        avl_read,
  output logic        avl_write,
  output logic [31:0] avl_writedata,
  output logic [3:0]  avl_byteenable,
  input  logic        avl_waitrequest,
  input  logic [31:0] avl_readdata,
  input  logic        avl_readdatavalid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // Counter only has to represent 0..TIMEOUT-1; the abort fires on the last value.
  localparam int unsigned           CNT_W      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic                  c_TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0]      c_CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic              r_write;
  logic [31:0]       r_addr;
  logic [1:0]        r_size;
  logic              r_sext;
  logic [31:0]       r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_rdata;
  logic              r_abort;

  logic              w_capture;
  logic              w_timeout;
  logic              w_cnt_hit;
  logic [1:0]        w_lane;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_word;
  logic [31:0]       w_rd_ext;

  assign w_lane    = r_addr[1:0];
  assign w_cnt_hit = c_TO_EN && (r_cnt == c_CNT_LAST);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_wdata;
    case (r_size)
      2'd0: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{r_wdata[7:0]}};
      end
      2'd1: begin
        w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_wdata;
      end
    endcase
  end

  assign w_byte = avl_readdata[{w_lane, 3'b000} +: 8];
  assign w_half = r_addr[1] ? avl_readdata[31:16] : avl_readdata[15:0];

`ifdef CORE_MEM_UNALIGNED_ROTATE_EN
  logic [63:0] w_rot;
  assign w_rot  = {avl_readdata, avl_readdata} >> {w_lane, 3'b000};
  assign w_word = w_rot[31:0];
`else
  assign w_word = avl_readdata;
`endif

  always_comb begin
    w_rd_ext = w_word;
    case (r_size)
      2'd0:    w_rd_ext = {{24{r_sext & w_byte[7]}}, w_byte};
      2'd1:    w_rd_ext = {{16{r_sext & w_half[15]}}, w_half};
      default: w_rd_ext = w_word;
    endcase
  end

  // A completing handshake wins over a timeout landing in the same cycle.
  always_comb begin
    w_next    = r_state;
    w_capture = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_REQ;
        end
      end
      S_REQ: begin
        if (!avl_waitrequest && (r_write || avl_readdatavalid)) begin
          w_next    = S_DONE;
          w_capture = !r_write;
        end else if (w_cnt_hit) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end else if (!avl_waitrequest) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (avl_readdatavalid) begin
          w_next    = S_DONE;
          w_capture = 1'b1;
        end else if (w_cnt_hit) begin
          w_next    = S_DONE;
          w_timeout = 1'b1;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_sext  <= 1'b0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_write <= write;
        r_addr  <= addr;
        r_size  <= size;
        r_sext  <= sign_extend;
        r_wdata <= wdata;
      end
      if (r_state == S_IDLE) begin
        r_cnt <= '0;
      end else if (r_state == S_REQ || r_state == S_RESP) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state != S_DONE && w_next == S_DONE) begin
        r_rdata <= w_capture ? w_rd_ext : 32'd0;
        r_abort <= w_timeout;
      end
    end
  end

  assign busy           = (r_state != S_IDLE);
  assign mem_ready      = (r_state == S_DONE);
  assign abort          = (r_state == S_DONE) && r_abort;
  assign rdata          = (r_state == S_DONE) ? r_rdata : 32'd0;
  assign avl_read       = (r_state == S_REQ) && !r_write;
  assign avl_write      = (r_state == S_REQ) && r_write;
  assign avl_address    = (r_state == S_REQ) ? r_addr[31:2] : 30'd0;
  assign avl_byteenable = (r_state == S_REQ) ? w_be : 4'd0;
  assign avl_writedata  = (r_state == S_REQ) ? w_wdata : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_core_mem_port.sv
// Testbench for core_mem_port: scripted Avalon slave, queue scoreboard and
// an independent byte-lane reference model.
`default_nettype none

module tb_core_mem_port;

  localparam int T = 4;

  logic        clk, rst, start, write, sign_extend;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  size;
  logic        mem_ready, abort, busy;
  logic [29:0] avl_address;
  logic        avl_read, avl_write;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic        avl_waitrequest, avl_readdatavalid;
  logic [31:0] avl_readdata;

  core_mem_port #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .start(start), .write(write), .addr(addr),
    .size(size), .sign_extend(sign_extend), .wdata(wdata), .rdata(rdata),
    .mem_ready(mem_ready), .abort(abort), .busy(busy),
    .avl_address(avl_address), .avl_read(avl_read), .avl_write(avl_write),
    .avl_writedata(avl_writedata), .avl_byteenable(avl_byteenable),
    .avl_waitrequest(avl_waitrequest), .avl_readdata(avl_readdata),
    .avl_readdatavalid(avl_readdatavalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        ab;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ncyc    = 0;
  int   acc     = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] model_be(input logic [1:0] a, input logic [1:0] sz);
    logic [3:0] be;
    for (int i = 0; i < 4; i++) begin
      if (sz == 2'd0)      be[i] = (i == int'(a));
      else if (sz == 2'd1) be[i] = ((i / 2) == int'(a[1]));
      else                 be[i] = 1'b1;
    end
    return be;
  endfunction

  function automatic logic [31:0] model_wd(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
      if (sz == 2'd0)      v[8*i +: 8] = wd[7:0];
      else if (sz == 2'd1) v[8*i +: 8] = wd[8*(i % 2) +: 8];
      else                 v[8*i +: 8] = wd[8*i +: 8];
    end
    return v;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] rd, input logic [1:0] a,
                                            input logic [1:0] sz, input logic sx);
    logic [7:0]  b [4];
    logic [31:0] v;
    int          h;
    for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
    if (sz == 2'd0) begin
      v = {24'd0, b[a]};
      return (sx && b[a][7]) ? (v | 32'hFFFF_FF00) : v;
    end
    if (sz == 2'd1) begin
      h = a[1] ? 2 : 0;
      v = {16'd0, b[h+1], b[h]};
      return (sx && b[h+1][7]) ? (v | 32'hFFFF_0000) : v;
    end
    for (int i = 0; i < 4; i++) begin
`ifdef CORE_MEM_UNALIGNED_ROTATE_EN
      v[8*i +: 8] = b[(i + int'(a)) % 4];
`else
      v[8*i +: 8] = b[i];
`endif
    end
    return v;
  endfunction

  // Monitor: timestamps acceptances and scores every completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!rst && start && !busy) acc = ncyc;
      if (mem_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_mem_ready", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rdata", rdata, e.rd);
          chk("abort", {31'd0, abort}, {31'd0, e.ab});
          chk("latency", ncyc - acc, e.lat);
          chk("busy_at_done", {31'd0, busy}, 32'd1);
        end
      end else if (abort) begin
        chk("abort_without_ready", {31'd0, abort}, 32'd0);
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_ready"}, {31'd0, mem_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_abort"}, {31'd0, abort}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_avl_rw"}, {30'd0, avl_read, avl_write}, 32'd0);
    chk({tag, "_avl_addr"}, {2'd0, avl_address}, 32'd0);
    chk({tag, "_avl_be"}, {28'd0, avl_byteenable}, 32'd0);
    chk({tag, "_avl_wd"}, avl_writedata, 32'd0);
  endtask

  task automatic idle_bus();
    avl_waitrequest   = 1'b0;
    avl_readdatavalid = 1'b0;
    avl_readdata      = $urandom;
  endtask

  // Entered and left just after a rising edge. w = waitrequest cycles,
  // l = cycles from command acceptance to readdatavalid (reads only).
  task automatic run_txn(input logic wr, input logic [31:0] ad, input logic [1:0] sz,
                         input logic sx, input logic [31:0] wd, input logic [31:0] rd,
                         input int w, input int l);
    exp_t e;
    int   c, lastk, done_idx, rl, guard;
    logic ab;
    c        = wr ? w : w + l;
    ab       = (c >= T);
    done_idx = ab ? T : c + 1;
    rl       = (w < T) ? w : T - 1;
    lastk    = c;
    e.rd     = (wr || ab) ? 32'd0 : model_rd(rd, ad[1:0], sz, sx);
    e.ab     = ab;
    e.lat    = done_idx + 1;
    q.push_back(e);

    start = 1'b1; write = wr; addr = ad; size = sz; sign_extend = sx; wdata = wd;
    idle_bus();
    @(posedge clk); #1;
    for (int k = 0; k <= lastk; k++) begin
      start             = (k <= done_idx) ? 1'($urandom) : 1'b0;
      write             = 1'($urandom);
      addr              = $urandom;
      size              = 2'($urandom);
      sign_extend       = 1'($urandom);
      wdata             = $urandom;
      avl_waitrequest   = (k < w);
      avl_readdatavalid = !wr && (k == w + l);
      avl_readdata      = avl_readdatavalid ? rd : $urandom;
      @(negedge clk);
      chk("avl_read", {31'd0, avl_read}, {31'd0, (!wr && k <= rl)});
      chk("avl_write", {31'd0, avl_write}, {31'd0, (wr && k <= rl)});
      chk("busy", {31'd0, busy}, {31'd0, (k <= done_idx)});
      if (k <= rl) begin
        chk("avl_address", {2'd0, avl_address}, {2'd0, ad[31:2]});
        chk("avl_be", {28'd0, avl_byteenable}, {28'd0, model_be(ad[1:0], sz)});
        if (wr) chk("avl_wdata", avl_writedata, model_wd(wd, sz));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    idle_bus();
    guard = 0;
    while (busy && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 20) chk("busy_stuck", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    rst = 1'b1; start = 1'b0; write = 1'b0; addr = '0; size = '0;
    sign_extend = 1'b0; wdata = '0;
    idle_bus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_txn(1'b0, 32'h0000_1000, 2'd2, 1'b0, 32'd0, 32'hDEAD_BEEF, 0, 0);
    run_txn(1'b1, 32'h0000_2003, 2'd0, 1'b0, 32'h0000_00A5, 32'd0, 3, 0);
    run_txn(1'b0, 32'h0000_0002, 2'd1, 1'b1, 32'd0, 32'h8001_1234, 0, 1);
    run_txn(1'b0, 32'h0000_0002, 2'd1, 1'b0, 32'd0, 32'h8001_1234, 0, 1);
    run_txn(1'b0, 32'h0000_0001, 2'd2, 1'b0, 32'd0, 32'h4433_2211, 0, 0);
    run_txn(1'b0, 32'h0000_0040, 2'd2, 1'b0, 32'd0, 32'h1234_5678, 10, 0);

    // Reset while waiting for read data in RESP.
    start = 1'b1; write = 1'b0; addr = 32'h0000_0100; size = 2'd2; sign_extend = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("resp_busy", {31'd0, busy}, 32'd1);
    chk("resp_read_low", {31'd0, avl_read}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    avl_readdatavalid = 1'b1;
    avl_readdata      = 32'hCAFE_F00D;
    @(negedge clk);
    chk_zero("mid_reset");
    @(posedge clk); #1;
    idle_bus();
    repeat (2) @(posedge clk);
    #1;
    run_txn(1'b0, 32'h0000_0100, 2'd2, 1'b0, 32'd0, 32'hCAFE_F00D, 1, 1);

    for (int n = 0; n < 40; n++) begin
      logic wr;
      wr = 1'($urandom);
      run_txn(wr, $urandom, 2'($urandom), 1'($urandom), $urandom, $urandom,
              int'($urandom_range(0, 3)), wr ? 0 : int'($urandom_range(0, 2)));
    end

    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("pending_responses", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
